backward_pass: RTL and testbench



---
 rtl/dt_pkg.sv | 37 +++
 rtl/backward_pass_if.sv | 30 +++
 rtl/min4_inc.sv | 33 +++
 rtl/backward_pass.sv | 150 +++++++++++++++
 tb/tb_backward_pass.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants and state type for the distance-transform passes
// Purpose: image geometry, scan limits, neighbour offsets and the pass FSM state
//          type, shared by the forward and backward passes.
// Ports:   none (package).
package dt_pkg;

  localparam int W_IMG  = 128;
  localparam int ADDR_W = 14;

  // Interior scan limits: row 126/col 126 down to row 1/col 1.
  localparam logic [ADDR_W-1:0] FIRST_ADDR = 14'd16254;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = 14'd129;

  // Neighbour offsets relative to the center address.
  localparam logic [ADDR_W-1:0] OFF_E  = 14'd1;
  localparam logic [ADDR_W-1:0] OFF_SW = 14'd127;
  localparam logic [ADDR_W-1:0] OFF_S  = 14'd128;
  localparam logic [ADDR_W-1:0] OFF_SE = 14'd129;

  // Step from col 1 of one row to col 126 of the row above.
  localparam logic [ADDR_W-1:0] ROW_WRAP = 14'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_C,
    ST_CHK,
    ST_RD_E,
    ST_RD_SW,
    ST_RD_S,
    ST_RD_SE,
    ST_CALC,
    ST_WR,
    ST_NEXT,
    ST_DONE
  } dt_state_t;

endpackage

// File: rtl/backward_pass_if.sv
// rtl/backward_pass_if.sv - result RAM port bundle for the backward pass
// Purpose: groups the result RAM read/write bus.
// Ports:   res_rd/res_wr strobes, res_addr, res_do (write data), res_di (read
//          data, valid one cycle after a read strobe).
//          master: pass engine side; slave: RAM side.
interface backward_pass_if;

  logic                      res_rd;
  logic                      res_wr;
  logic [dt_pkg::ADDR_W-1:0] res_addr;
  logic [7:0]                res_do;
  logic [7:0]                res_di;

  modport master (
    output res_rd,
    output res_wr,
    output res_addr,
    output res_do,
    input  res_di
  );

  modport slave (
    input  res_rd,
    input  res_wr,
    input  res_addr,
    input  res_do,
    output res_di
  );

endinterface

// File: rtl/min4_inc.sv
// rtl/min4_inc.sv - 4-input unsigned minimum, +1, and compare with the center
// Purpose: result = min(center, min(n0..n3)+1); a 255 minimum never wraps.
// Ports:   center, n0..n3 inputs (8 bit); result output (8 bit). Combinational.
module min4_inc (
  input  logic [7:0] center,
  input  logic [7:0] n0,
  input  logic [7:0] n1,
  input  logic [7:0] n2,
  input  logic [7:0] n3,
  output logic [7:0] result
);

  logic [7:0] m01;
  logic [7:0] m23;
  logic [7:0] m;
  logic [8:0] cand;

  always_comb begin
    m01  = (n1 < n0) ? n1 : n0;
    m23  = (n3 < n2) ? n3 : n2;
    m    = (m23 < m01) ? m23 : m01;
    cand = {1'b0, m} + 9'd1;
    // A carry out means the candidate is 256, which can never beat the center.
    if (cand[8]) begin
      result = center;
    end else if (cand[7:0] < center) begin
      result = cand[7:0];
    end else begin
      result = center;
    end
  end

endmodule

// File: rtl/backward_pass.sv
// rtl/backward_pass.sv - backward raster pass of the distance-transform engine
// Purpose: after fp_done, scans the RAM interior from bottom-right to top-left
//          and rewrites each foreground pixel with min(C, min(E,SW,S,SE)+1).
// Ports:   clk, reset (async, active high), fp_done (start level, IDLE only),
//          ram (backward_pass_if.master), bp_done (sticky completion).
// Config:  BP_WRITE_SKIP_EN - when defined, unchanged pixels are not written.
module backward_pass
  import dt_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            fp_done,
  backward_pass_if.master ram,
  output logic            bp_done
);

  dt_state_t         state, state_n;
  logic [ADDR_W-1:0] c_addr, c_addr_n;
  logic [ADDR_W-1:0] addr_n;
  logic              rd_n;
  logic              wr_n;
  logic [7:0]        do_n;
  logic [7:0]        center_q, e_q, sw_q, s_q;
  logic [7:0]        result;

  // SE is taken straight off the read bus in CALC.
  min4_inc u_min4_inc (
    .center (center_q),
    .n0     (e_q),
    .n1     (sw_q),
    .n2     (s_q),
    .n3     (ram.res_di),
    .result (result)
  );

  // Outputs are registered: each branch sets the bus values for the state
  // being entered.
  always_comb begin
    state_n  = state;
    c_addr_n = c_addr;
    addr_n   = ram.res_addr;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    do_n     = ram.res_do;
    case (state)
      ST_IDLE: begin
        if (fp_done) begin
          state_n = ST_RD_C;
          rd_n    = 1'b1;
          addr_n  = c_addr;
        end
      end
      ST_RD_C: state_n = ST_CHK;
      ST_CHK: begin
        if (ram.res_di == 8'd0) begin
          state_n = ST_NEXT;
        end else begin
          state_n = ST_RD_E;
          rd_n    = 1'b1;
          addr_n  = c_addr + OFF_E;
        end
      end
      ST_RD_E: begin
        state_n = ST_RD_SW;
        rd_n    = 1'b1;
        addr_n  = c_addr + OFF_SW;
      end
      ST_RD_SW: begin
        state_n = ST_RD_S;
        rd_n    = 1'b1;
        addr_n  = c_addr + OFF_S;
      end
      ST_RD_S: begin
        state_n = ST_RD_SE;
        rd_n    = 1'b1;
        addr_n  = c_addr + OFF_SE;
      end
      ST_RD_SE: state_n = ST_CALC;
      ST_CALC: begin
        state_n = ST_WR;
        wr_n    = 1'b1;
        addr_n  = c_addr;
        do_n    = result;
`ifdef BP_WRITE_SKIP_EN
        if (result == center_q) begin
          state_n = ST_NEXT;
          wr_n    = 1'b0;
          addr_n  = ram.res_addr;
          do_n    = ram.res_do;
        end
`endif
      end
      ST_WR: state_n = ST_NEXT;
      ST_NEXT: begin
        if (c_addr == LAST_ADDR) begin
          state_n = ST_DONE;
        end else begin
          // Low 7 bits equal to 1 means col 1: jump to col 126 of the row above.
          c_addr_n = (c_addr[6:0] == 7'd1) ? (c_addr - ROW_WRAP) : (c_addr - OFF_E);
          state_n  = ST_RD_C;
          rd_n     = 1'b1;
          addr_n   = c_addr_n;
        end
      end
      ST_DONE: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      c_addr       <= FIRST_ADDR;
      ram.res_rd   <= 1'b0;
      ram.res_wr   <= 1'b0;
      ram.res_addr <= FIRST_ADDR;
      ram.res_do   <= 8'd0;
      bp_done      <= 1'b0;
    end else begin
      state        <= state_n;
      c_addr       <= c_addr_n;
      ram.res_rd   <= rd_n;
      ram.res_wr   <= wr_n;
      ram.res_addr <= addr_n;
      ram.res_do   <= do_n;
      // Raised from the DONE state register, so it lags entry into DONE by one cycle.
      bp_done      <= bp_done | (state == ST_DONE);
    end
  end

  // Read data arrives one cycle after its strobe, so each neighbour is
  // captured in the state following the one that presented it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      center_q <= 8'd0;
      e_q      <= 8'd0;
      sw_q     <= 8'd0;
      s_q      <= 8'd0;
    end else begin
      case (state)
        ST_CHK:   center_q <= ram.res_di;
        ST_RD_SW: e_q      <= ram.res_di;
        ST_RD_S:  sw_q     <= ram.res_di;
        ST_RD_SE: s_q      <= ram.res_di;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_backward_pass.sv
// tb/tb_backward_pass.sv - randomized self-checking bench for backward_pass
`timescale 1ns/1ps
module tb_backward_pass;
  import dt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic fp_done;
  logic bp_done;

  backward_pass_if bus();

  backward_pass dut (
    .clk     (clk),
    .reset   (reset),
    .fp_done (fp_done),
    .ram     (bus),
    .bp_done (bp_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram  [0:16383];
  logic [7:0] img0 [0:16383];
  logic [7:0] mdl  [0:16383];

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  dat;
  } cyc_t;

  cyc_t exp_q[$];

  // Behavioural result RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.res_rd) bus.res_di <= ram[bus.res_addr];
    if (bus.res_wr) ram[bus.res_addr] = bus.res_do;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Distance rule in plain integer arithmetic.
  function automatic int bp_rule(input int c, input int e, input int sw, input int s, input int se);
    int m;
    m = e;
    if (sw < m) m = sw;
    if (s < m)  m = s;
    if (se < m) m = se;
    return (m + 1 < c) ? m + 1 : c;
  endfunction

  function automatic void push(input logic rd, input logic wr, input int a, input int d);
    cyc_t c;
    c.rd   = rd;
    c.wr   = wr;
    c.addr = 14'(a);
    c.dat  = 8'(d);
    exp_q.push_back(c);
  endfunction

  // Expected bus activity per cycle, from the first RD_C through the first DONE cycle.
  task automatic build_trace(input bit zero_img);
    int v;
    exp_q.delete();
    for (int a = 0; a < 16384; a++) mdl[a] = zero_img ? 8'd0 : img0[a];
    for (int r = 126; r >= 1; r--) begin
      for (int col = 126; col >= 1; col--) begin
        int a;
        a = r * 128 + col;
        push(1'b1, 1'b0, a, 0);
        push(1'b0, 1'b0, 0, 0);
        if (mdl[a] != 8'd0) begin
          push(1'b1, 1'b0, a + 1, 0);
          push(1'b1, 1'b0, a + 127, 0);
          push(1'b1, 1'b0, a + 128, 0);
          push(1'b1, 1'b0, a + 129, 0);
          push(1'b0, 1'b0, 0, 0);
          v = bp_rule(int'(mdl[a]), int'(mdl[a+1]), int'(mdl[a+127]), int'(mdl[a+128]), int'(mdl[a+129]));
`ifdef BP_WRITE_SKIP_EN
          if (v != int'(mdl[a])) push(1'b0, 1'b1, a, v);
`else
          push(1'b0, 1'b1, a, v);
`endif
          mdl[a] = 8'(v);
        end
        push(1'b0, 1'b0, 0, 0);
      end
    end
    push(1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_trace();
    int base;
    logic [24:0] act;
    logic [24:0] expv;
    base = errors;
    for (int i = 0; i < exp_q.size(); i++) begin
      act  = {bus.res_rd, bus.res_wr,
              (bus.res_rd | bus.res_wr) ? bus.res_addr : 14'd0,
              bus.res_wr ? bus.res_do : 8'd0, bp_done};
      expv = {exp_q[i].rd, exp_q[i].wr,
              (exp_q[i].rd | exp_q[i].wr) ? exp_q[i].addr : 14'd0,
              exp_q[i].wr ? exp_q[i].dat : 8'd0, 1'b0};
      chk($sformatf("trace[%0d] {rd,wr,addr,do,bp_done}", i), 64'(act), 64'(expv));
      if (errors - base >= 10) begin
        $display("trace compare abandoned at cycle %0d", i);
        break;
      end
      fp_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("done_hold[%0d] {bp_done,rd,wr}", k), 64'({bp_done, bus.res_rd, bus.res_wr}), 64'(3'b100));
      fp_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    fp_done = 1'b0;
  endtask

  initial begin
    int n;
    int nmis;
    int first_bad;
    int nwr;
    reset   = 1'b1;
    fp_done = 1'b0;

    for (int a = 0; a < 16384; a++) img0[a] = 8'd0;
    for (int r = 1; r <= 126; r++) begin
      for (int col = 1; col <= 126; col++) begin
        if ($urandom_range(0, 15) == 0)
          img0[r*128+col] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 4))
                                                         : 8'($urandom_range(1, 255));
      end
    end
    img0[16254] = 8'd5;
    img0[8000] = 8'd9;   img0[8001] = 8'd7;   img0[8127] = 8'd2;
    img0[8128] = 8'd6;   img0[8129] = 8'd5;
    img0[4000] = 8'd200; img0[4001] = 8'd255; img0[4127] = 8'd255;
    img0[4128] = 8'd255; img0[4129] = 8'd255;
    img0[6000] = 8'd3;   img0[6001] = 8'd4;   img0[6127] = 8'd4;
    img0[6128] = 8'd4;   img0[6129] = 8'd4;
    for (int a = 0; a < 16384; a++) ram[a] = img0[a];

    // Hand-computed values pinning the model.
    chk("rule 9 / 7,2,6,5", 64'(bp_rule(9, 7, 2, 6, 5)), 64'd3);
    chk("rule 5 / zeros", 64'(bp_rule(5, 0, 0, 0, 0)), 64'd1);
    chk("rule 3 / 4s", 64'(bp_rule(3, 4, 4, 4, 4)), 64'd3);
    chk("rule 200 / 255s", 64'(bp_rule(200, 255, 255, 255, 255)), 64'd200);
    build_trace(1'b1);
    chk("zero image cycles", 64'(exp_q.size() - 1), 64'd47628);
    chk("zero image first addr", 64'(exp_q[0].addr), 64'd16254);
    chk("zero image wrap from", 64'(exp_q[375].addr), 64'd16129);
    chk("zero image wrap to", 64'(exp_q[378].addr), 64'd16126);
    chk("zero image last read", 64'(exp_q[47625].addr), 64'd129);
    nwr = 0;
    foreach (exp_q[i]) if (exp_q[i].wr) nwr++;
    chk("zero image writes", 64'(nwr), 64'd0);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("reset res_rd", 64'(bus.res_rd), 64'd0);
    chk("reset res_wr", 64'(bus.res_wr), 64'd0);
    chk("reset res_do", 64'(bus.res_do), 64'd0);
    chk("reset bp_done", 64'(bp_done), 64'd0);
    chk("reset res_addr", 64'(bus.res_addr), 64'd16254);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // First run, aborted by reset during the first write.
    fp_done = 1'b1;
    @(posedge clk); #1;
    fp_done = 1'b0;
    chk("run1 first {rd,addr}", 64'({bus.res_rd, bus.res_addr}), 64'({1'b1, 14'd16254}));
    n = 0;
    while (!bus.res_wr && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("run1 write seen", 64'(bus.res_wr), 64'd1);
    chk("run1 write addr", 64'(bus.res_addr), 64'd16254);
    chk("run1 write data", 64'(bus.res_do), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset in WR res_wr", 64'(bus.res_wr), 64'd0);
    chk("reset in WR res_rd", 64'(bus.res_rd), 64'd0);
    chk("reset in WR res_addr", 64'(bus.res_addr), 64'd16254);
    chk("reset in WR res_do", 64'(bus.res_do), 64'd0);
    @(posedge clk); #1;
    chk("aborted write not stored", 64'(ram[16254]), 64'd5);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle after reset[%0d] {rd,wr}", k), 64'({bus.res_rd, bus.res_wr}), 64'd0);
    end

    // Full rescan of the random image against the model trace.
    build_trace(1'b0);
    fp_done = 1'b1;
    @(posedge clk); #1;
    run_trace();

    nmis = 0;
    first_bad = -1;
    for (int a = 0; a < 16384; a++) begin
      if (ram[a] !== mdl[a]) begin
        if (first_bad < 0) first_bad = a;
        nmis++;
      end
    end
    chk($sformatf("final map mismatches (first at %0d)", first_bad), 64'(nmis), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
